typedef_frame_rx: RTL and testbench

- Parametrised byte-stream frame receiver. Accepts a stream of DATA_W-bit words and finds a start-of-frame word. Captures a length word, then accumulates the payload into a modular sum and XOR check.
- Presents the result until it is acknowledged.
- Element type, length type and state type are typedefs declared in package frame_pkg:
  - state is an enum of width 2 with explicit encodings.
  - SOF_VAL is a package parameter of the element typedef.
- Exercises package typedefs, enums and parameters inside real sequential logic in the svtypes suite.

---
 rtl/typedef_frame_rx.sv | 208 ++++++++++++++++++++
 tb/tb_typedef_frame_rx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typedef_frame_rx.sv
// typedef_frame_rx: parametrised word-stream frame receiver.
//
// Frame format on the input stream: SOF_VAL, length L (1..MAX_LEN), then
// L payload words. The receiver reports the payload length and the modular
// sum of the payload. It holds the result until the consumer acknowledges it.
//
// Optional build macro: TYPEDEF_FRAME_CHECK_EN. When it is defined, every
// frame carries one extra check word after the payload. That word must equal
// the XOR of the payload words. A mismatch drops the frame and pulses err.
//
// Handshake semantics (both sides):
//   input side  - a word transfers on a rising edge where in_valid && in_ready.
//                 in_ready is a pure decode of the state (low only in DONE).
//                 in_valid may drop at any time with no timeout.
//   output side - out_valid is high exactly while in DONE. out_ack is sampled
//                 only while out_valid is high. The next SOF can transfer in
//                 the cycle after the acknowledge.
// The FSM state is exported on the state port for observation.

package frame_pkg;
  parameter int DATA_W  = 8;
  parameter int MAX_LEN = 15;
  parameter int LEN_W   = $clog2(MAX_LEN + 1);

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [LEN_W-1:0]  len_t;

  parameter elem_t SOF_VAL = 8'hBB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
endpackage

module typedef_frame_rx #(
  parameter int              DATA_W  = frame_pkg::DATA_W,
  parameter int              MAX_LEN = frame_pkg::MAX_LEN,
  parameter frame_pkg::elem_t SOF_VAL = frame_pkg::SOF_VAL,
  parameter int              DROP_W  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ack,
  output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
  output logic [DATA_W-1:0]              frame_sum,
  output logic                           err,
  output logic [DROP_W-1:0]              drop_cnt,
  output frame_pkg::state_t              state
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  frame_pkg::state_t  state_q, state_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [LEN_W-1:0]   rem_q,   rem_d;
  logic [DATA_W-1:0]  sum_q,   sum_d;
  logic [DROP_W-1:0]  drop_q,  drop_d;
  logic               err_q,   err_d;
`ifdef TYPEDEF_FRAME_CHECK_EN
  logic [DATA_W-1:0]  xor_q,   xor_d;
  // Set after the last payload word: the next transfer is the check word.
  logic               check_q, check_d;
`endif

  logic xfer;
  logic len_bad;

  // Handshake decode: the receiver stalls the stream only while presenting a result.
  always_comb begin
    in_ready  = (state_q != frame_pkg::ST_DONE);
    out_valid = (state_q == frame_pkg::ST_DONE);
    xfer      = in_valid && in_ready;
    // Compared at full word width so large values cannot alias into range.
    len_bad   = (in_data == '0) || (in_data > DATA_W'(MAX_LEN));
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= frame_pkg::ST_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
`ifdef TYPEDEF_FRAME_CHECK_EN
      xor_q   <= '0;
      check_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
`ifdef TYPEDEF_FRAME_CHECK_EN
      xor_q   <= xor_d;
      check_q <= check_d;
`endif
    end
  end

  // Next-state and datapath update; every target gets its hold value first.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    drop_d  = drop_q;
    err_d   = 1'b0;
`ifdef TYPEDEF_FRAME_CHECK_EN
    xor_d   = xor_q;
    check_d = check_q;
`endif

    case (state_q)
      frame_pkg::ST_IDLE: begin
        if (xfer) begin
          if (in_data == SOF_VAL) begin
            state_d = frame_pkg::ST_LEN;
          end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end
      end

      frame_pkg::ST_LEN: begin
        if (xfer) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = frame_pkg::ST_IDLE;
          end else begin
            len_d   = in_data[LEN_W-1:0];
            rem_d   = in_data[LEN_W-1:0];
            sum_d   = '0;
`ifdef TYPEDEF_FRAME_CHECK_EN
            xor_d   = '0;
            check_d = 1'b0;
`endif
            state_d = frame_pkg::ST_PAYLOAD;
          end
        end
      end

      frame_pkg::ST_PAYLOAD: begin
        if (xfer) begin
`ifdef TYPEDEF_FRAME_CHECK_EN
          if (check_q) begin
            check_d = 1'b0;
            if (in_data == xor_q) begin
              state_d = frame_pkg::ST_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = frame_pkg::ST_IDLE;
            end
          end else begin
            sum_d = sum_q + in_data;
            xor_d = xor_q ^ in_data;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              check_d = 1'b1;
            end
          end
`else
          sum_d = sum_q + in_data;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = frame_pkg::ST_DONE;
          end
`endif
        end
      end

      frame_pkg::ST_DONE: begin
        if (out_ack) begin
          state_d = frame_pkg::ST_IDLE;
        end
      end

      default: begin
        state_d = frame_pkg::ST_IDLE;
      end
    endcase

    assert (state_q inside {frame_pkg::ST_IDLE, frame_pkg::ST_LEN,
                            frame_pkg::ST_PAYLOAD, frame_pkg::ST_DONE});
    assert (in_ready == (state_q != frame_pkg::ST_DONE));
    assert (out_valid == (state_q == frame_pkg::ST_DONE));
  end

  // Result and status outputs come straight from registers.
  always_comb begin
    frame_len = len_q;
    frame_sum = sum_q;
    err       = err_q;
    drop_cnt  = drop_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_typedef_frame_rx.sv
// Self-checking bench for typedef_frame_rx. The reference model computes
// expected results from the frame rules: payload sum, payload XOR and a
// saturating drop count. Define TYPEDEF_FRAME_CHECK_EN to exercise the
// check-word build.
module tb_typedef_frame_rx;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [7:0] SOF = 8'hBB;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ack;
  logic [3:0] frame_len;
  logic [7:0] frame_sum;
  logic       err;
  logic [3:0] drop_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef_frame_rx #(.DATA_W(8), .MAX_LEN(15), .SOF_VAL(8'hBB), .DROP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ack(out_ack),
    .frame_len(frame_len), .frame_sum(frame_sum), .err(err),
    .drop_cnt(drop_cnt), .state(state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_sum(input byte_q_t pl);
    int s = 0;
    foreach (pl[i]) s = s + int'(pl[i]);
    return 8'(s % 256);
  endfunction

  function automatic logic [7:0] model_xor(input byte_q_t pl);
    logic [7:0] x = 8'h00;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  function automatic int model_drop(input int cur, input int add);
    return (cur + add > 15) ? 15 : cur + add;
  endfunction

  // ---------------- drivers (start and end at negedge) ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] len, input byte_q_t pl, input int max_gap);
    send_word(SOF);
    gap(max_gap);
    send_word(len);
    foreach (pl[i]) begin
      gap(max_gap);
      send_word(pl[i]);
    end
`ifdef TYPEDEF_FRAME_CHECK_EN
    gap(max_gap);
    send_word(model_xor(pl));
`endif
  endtask

  task automatic ack_result();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({state, in_ready, out_valid, err, frame_len, frame_sum, drop_cnt} !==
        {2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_values: state=%0d rdy=%b ov=%b err=%b len=%0d sum=%h drop=%0d required 0,1,0,0,0,00,0",
               state, in_ready, out_valid, err, frame_len, frame_sum, drop_cnt);
    end
  endtask

  task automatic test_basic_frame();
    byte_q_t pl;
    logic [7:0] last;
    pl = {8'h10, 8'h20, 8'hF5};
    send_word(SOF); send_word(8'h03); send_word(8'h10); send_word(8'h20);
`ifdef TYPEDEF_FRAME_CHECK_EN
    send_word(8'hF5);
    last = model_xor(pl);
`else
    last = 8'hF5;
`endif
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
    end
    send_word(last);
    n_cmp++;
    if (out_valid !== 1'b1 || frame_len !== 4'd3 || frame_sum !== model_sum(pl)) begin
      n_bad++;
      $display("FAIL basic_result: ov=%b len=%0d sum=%h required 1,3,%h",
               out_valid, frame_len, frame_sum, model_sum(pl));
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || state !== 2'd3) begin
      n_bad++; $display("FAIL basic_hold: rdy=%b state=%0d required 0,3", in_ready, state);
    end
    ack_result();
    n_cmp++;
    if (state !== 2'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_ack: state=%0d ov=%b required 0,0", state, out_valid);
    end
  endtask

  task automatic test_drops();
    byte_q_t pl;
    int exp_drop;
    logic [7:0] w;
    do_reset();
    send_word(8'hAA); send_word(8'hCC); send_word(8'h00);
    exp_drop = 3;
    n_cmp++;
    if (drop_cnt !== 4'(exp_drop)) begin
      n_bad++; $display("FAIL drop_three: drop=%0d required %0d", drop_cnt, exp_drop);
    end
    pl = {8'h7F};
    send_frame(8'h01, pl, 0);
    n_cmp++;
    if (out_valid !== 1'b1 || frame_sum !== 8'h7F || frame_len !== 4'd1 || drop_cnt !== 4'(exp_drop)) begin
      n_bad++;
      $display("FAIL drop_frame: ov=%b sum=%h len=%0d drop=%0d required 1,7f,1,%0d",
               out_valid, frame_sum, frame_len, drop_cnt, exp_drop);
    end
    ack_result();
    for (int k = 0; k < 17; k++) begin
      w = 8'($urandom_range(0, 255));
      if (w == SOF) w = 8'h00;
      send_word(w);
      exp_drop = model_drop(exp_drop, 1);
      n_cmp++;
      if (drop_cnt !== 4'(exp_drop)) begin
        n_bad++; $display("FAIL drop_sat_%0d: drop=%0d required %0d", k, drop_cnt, exp_drop);
      end
    end
  endtask

  task automatic test_len_errors();
    logic [7:0] bad_len[2];
    bad_len[0] = 8'h00;
    bad_len[1] = 8'h10;
    for (int k = 0; k < 2; k++) begin
      send_word(SOF);
      send_word(bad_len[k]);
      n_cmp++;
      if (err !== 1'b1 || out_valid !== 1'b0 || state !== 2'd0) begin
        n_bad++;
        $display("FAIL len_err_pulse_%0d: err=%b ov=%b state=%0d required 1,0,0",
                 k, err, out_valid, state);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL len_err_single_%0d: err=%b ov=%b required 0,0", k, err, out_valid);
      end
    end
  endtask

  task automatic test_stall_hold();
    byte_q_t pl;
    logic [3:0] drop_before;
    pl = {8'h01, 8'h02};
    drop_before = drop_cnt;
    send_word(SOF); @(negedge clk);
    send_word(8'h02); @(negedge clk);
    send_word(8'h01); @(negedge clk);
`ifdef TYPEDEF_FRAME_CHECK_EN
    send_word(8'h02); @(negedge clk);
    send_word(model_xor(pl));
`else
    send_word(8'h02);
`endif
    // Offer an SOF during DONE: it must be refused and not counted.
    in_valid = 1'b1;
    in_data  = SOF;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || frame_sum !== model_sum(pl) ||
          frame_len !== 4'd2 || drop_cnt !== drop_before) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: ov=%b rdy=%b sum=%h len=%0d drop=%0d required 1,0,%h,2,%0d",
                 k, out_valid, in_ready, frame_sum, frame_len, drop_cnt, model_sum(pl), drop_before);
      end
      @(negedge clk);
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_ack: state=%0d rdy=%b required 0,1", state, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++; $display("FAIL stall_next_sof: state=%0d required 1", state);
    end
    pl = {8'h7E};
    send_word(8'h01);
    send_word(8'h7E);
`ifdef TYPEDEF_FRAME_CHECK_EN
    send_word(model_xor(pl));
`endif
    n_cmp++;
    if (out_valid !== 1'b1 || frame_sum !== 8'h7E) begin
      n_bad++; $display("FAIL stall_second: ov=%b sum=%h required 1,7e", out_valid, frame_sum);
    end
    ack_result();
  endtask

  task automatic test_async_reset();
    byte_q_t pl;
    do_reset();
    send_word(8'h01); send_word(8'h02);
    send_word(SOF); send_word(8'h04); send_word(8'h11);
    n_cmp++;
    if (state !== 2'd2 || frame_sum !== 8'h11 || drop_cnt !== 4'd2) begin
      n_bad++; $display("FAIL areset_pre: state=%0d sum=%h drop=%0d required 2,11,2", state, frame_sum, drop_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, in_ready, out_valid, err, frame_len, frame_sum, drop_cnt} !==
        {2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL areset_now: state=%0d rdy=%b ov=%b err=%b len=%0d sum=%h drop=%0d required 0,1,0,0,0,00,0",
               state, in_ready, out_valid, err, frame_len, frame_sum, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pl = {8'h22};
    send_frame(8'h01, pl, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || frame_sum !== 8'h22 || frame_len !== 4'd1) begin
      n_bad++; $display("FAIL areset_next: ov=%b sum=%h len=%0d required 1,22,1", out_valid, frame_sum, frame_len);
    end
    ack_result();
  endtask

  task automatic test_back_to_back();
    byte_q_t pl;
    for (int f = 0; f < 3; f++) begin
      pl.delete();
      for (int i = 0; i <= f; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_frame(8'(f + 1), pl, 0);
      // Ack in the very cycle out_valid first shows.
      out_ack = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || frame_sum !== model_sum(pl) || frame_len !== 4'(f + 1)) begin
        n_bad++;
        $display("FAIL b2b_result_%0d: ov=%b sum=%h len=%0d required 1,%h,%0d",
                 f, out_valid, frame_sum, frame_len, model_sum(pl), f + 1);
      end
      @(negedge clk);
      out_ack = 1'b0;
      n_cmp++;
      if (state !== 2'd0 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL b2b_one_cycle_done_%0d: state=%0d ov=%b required 0,0", f, state, out_valid);
      end
    end
  endtask

  task automatic test_random_frames();
    byte_q_t pl;
    int exp_drop = 0;
    int junk;
    int len;
    logic [7:0] w;
    logic [7:0] exp_sum;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        w = 8'($urandom_range(0, 255));
        if (w == SOF) w = 8'h5A;
        send_word(w);
        gap(1);
      end
      exp_drop = model_drop(exp_drop, junk);
      if ($urandom_range(0, 4) == 0) begin
        w = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(16, 255));
        send_word(SOF);
        send_word(w);
        n_cmp++;
        if (err !== 1'b1 || out_valid !== 1'b0 || state !== 2'd0) begin
          n_bad++;
          $display("FAIL rand_err_%0d: len=%h err=%b ov=%b state=%0d required 1,0,0", it, w, err, out_valid, state);
        end
      end else begin
        len = $urandom_range(1, 15);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
        exp_q.push_back(model_sum(pl));
        send_frame(8'(len), pl, 2);
        n_cmp++;
        if (out_valid !== 1'b1 || frame_len !== 4'(len)) begin
          n_bad++;
          $display("FAIL rand_valid_%0d: ov=%b len=%0d required 1,%0d", it, out_valid, frame_len, len);
        end
        exp_sum = exp_q.pop_front();
        n_cmp++;
        if (frame_sum !== exp_sum) begin
          n_bad++; $display("FAIL rand_sum_%0d: sum=%h required %h", it, frame_sum, exp_sum);
        end
        gap(2);
        ack_result();
      end
      n_cmp++;
      if (drop_cnt !== 4'(exp_drop)) begin
        n_bad++; $display("FAIL rand_drop_%0d: drop=%0d required %0d", it, drop_cnt, exp_drop);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rand_queue_empty: left=%0d required 0", exp_q.size());
    end
  endtask

`ifdef TYPEDEF_FRAME_CHECK_EN
  task automatic test_check_word();
    send_word(SOF); send_word(8'h02); send_word(8'h0F); send_word(8'hF0); send_word(8'hFF);
    n_cmp++;
    if (out_valid !== 1'b1 || frame_sum !== 8'hFF) begin
      n_bad++; $display("FAIL check_good: ov=%b sum=%h required 1,ff", out_valid, frame_sum);
    end
    ack_result();
    send_word(SOF); send_word(8'h02); send_word(8'h0F); send_word(8'hF0); send_word(8'h00);
    n_cmp++;
    if (err !== 1'b1 || out_valid !== 1'b0 || state !== 2'd0) begin
      n_bad++; $display("FAIL check_bad: err=%b ov=%b state=%0d required 1,0,0", err, out_valid, state);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL check_bad_after: err=%b ov=%b required 0,0", err, out_valid);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ack = 1'b0;
    test_reset();
    test_basic_frame();
    test_drops();
    test_len_errors();
    test_stall_hold();
    test_async_reset();
    test_back_to_back();
    test_random_frames();
`ifdef TYPEDEF_FRAME_CHECK_EN
    test_check_word();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
